// File: rtl/tick_gen_multi.sv
// Multi-channel periodic tick generator: per-channel IDLE/COUNT/HOLD FSM with latched period/mode.
// Optional saturating per-channel tick counter enabled by macro TICK_GEN_TICK_CNT_EN.

module tick_gen_ch #(
  parameter int CW  = 8,
  parameter int TCW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] period,
  input  logic          oneshot,
  output logic          tick,
  output logic          busy
`ifdef TICK_GEN_TICK_CNT_EN
  ,
  output logic [TCW-1:0] tick_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TWO = CW'(2);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, pq, pq_nx;
  logic          mq, mq_nx;
  logic          at_end;

  assign at_end = (cnt == pq - ONE);
  assign tick   = (state == COUNT) && at_end;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pq_nx    = pq;
    mq_nx    = mq;
    case (state)
      IDLE: if (en) begin
        state_nx = COUNT;
        cnt_nx   = ONE;
        pq_nx    = (period < TWO) ? TWO : period;
        mq_nx    = oneshot;
      end
      COUNT: begin
        // the tick cycle ends the run regardless of en
        if (at_end) begin
          state_nx = mq ? HOLD : IDLE;
          cnt_nx   = '0;
        end else if (en) begin
          cnt_nx = cnt + ONE;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      HOLD: if (!en) state_nx = IDLE;
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pq    <= TWO;
      mq    <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      pq    <= TWO;
      mq    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pq    <= pq_nx;
      mq    <= mq_nx;
    end
  end

`ifdef TICK_GEN_TICK_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       tick_cnt <= '0;
    else if (clr)                    tick_cnt <= '0;
    else if (tick && tick_cnt != '1) tick_cnt <= tick_cnt + TCW'(1);
  end
`endif
endmodule

module tick_gen_multi #(
  parameter int NCH = 4,
  parameter int CW  = 8,
  parameter int TCW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [NCH-1:0]    en,
  input  logic [NCH*CW-1:0] period,
  input  logic [NCH-1:0]    oneshot,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    busy
`ifdef TICK_GEN_TICK_CNT_EN
  ,
  output logic [NCH*TCW-1:0] tick_cnt
`endif
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_gen_ch #(.CW(CW), .TCW(TCW)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .en      (en[i]),
      .period  (period[i*CW +: CW]),
      .oneshot (oneshot[i]),
      .tick    (tick[i]),
      .busy    (busy[i])
`ifdef TICK_GEN_TICK_CNT_EN
      ,
      .tick_cnt(tick_cnt[i*TCW +: TCW])
`endif
    );
  end
endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed + random bench for tick_gen_multi against a run-length reference model.
// Covers tick_cnt too when TICK_GEN_TICK_CNT_EN is defined.

module tb_tick_gen_multi;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int TCW = 4;
  localparam int TMAX = (1 << TCW) - 1;

  logic              clk = 1'b0;
  logic              reset, clr;
  logic [NCH-1:0]    en, oneshot;
  logic [NCH*CW-1:0] period;
  logic [NCH-1:0]    tick, busy;
`ifdef TICK_GEN_TICK_CNT_EN
  logic [NCH*TCW-1:0] tick_cnt;
`endif

  tick_gen_multi #(.NCH(NCH), .CW(CW), .TCW(TCW)) dut (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .en      (en),
    .period  (period),
    .oneshot (oneshot),
    .tick    (tick),
    .busy    (busy)
`ifdef TICK_GEN_TICK_CNT_EN
    ,
    .tick_cnt(tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: run = enabled edges since the start of the current run (0 = not running),
  // lp/lm = period/mode captured at start, held = parked after a one-shot tick.
  int run[NCH], lp[NCH], tc[NCH];
  bit lm[NCH], held[NCH];
  int n_cmp = 0, n_err = 0;

  function automatic bit m_tick(int i);
    return !held[i] && run[i] != 0 && run[i] == lp[i] - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      run[i] = 0; lp[i] = 2; lm[i] = 0; held[i] = 0; tc[i] = 0;
    end
  endtask

  task automatic model_edge();
    int p;
    if (reset || clr) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      if (m_tick(i) && tc[i] < TMAX) tc[i]++;
      if (held[i]) begin
        if (!en[i]) held[i] = 0;
      end else if (run[i] == 0) begin
        if (en[i]) begin
          p = int'(period[i*CW +: CW]);
          lp[i] = (p < 2) ? 2 : p;
          lm[i] = oneshot[i];
          run[i] = 1;
        end
      end else if (run[i] == lp[i] - 1) begin
        run[i] = 0;
        held[i] = lm[i];
      end else if (en[i]) begin
        run[i]++;
      end else begin
        run[i] = 0;
      end
    end
  endtask

  task automatic check(string tag);
    logic [NCH-1:0] et, eb;
    for (int i = 0; i < NCH; i++) begin
      et[i] = m_tick(i);
      eb[i] = held[i] || run[i] != 0;
    end
    n_cmp++;
    assert (tick === et) else begin
      n_err++;
      $error("FAIL %s tick observed=%b expected=%b t=%0t", tag, tick, et, $time);
    end
    n_cmp++;
    assert (busy === eb) else begin
      n_err++;
      $error("FAIL %s busy observed=%b expected=%b t=%0t", tag, busy, eb, $time);
    end
`ifdef TICK_GEN_TICK_CNT_EN
    begin
      logic [NCH*TCW-1:0] ec;
      for (int i = 0; i < NCH; i++) ec[i*TCW +: TCW] = TCW'(tc[i]);
      n_cmp++;
      assert (tick_cnt === ec) else begin
        n_err++;
        $error("FAIL %s tick_cnt observed=%h expected=%h t=%0t", tag, tick_cnt, ec, $time);
      end
    end
`endif
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic steps(int n, string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  int nt;

  initial begin
    reset = 1'b1; clr = 1'b0; en = '0; oneshot = '0; period = '0;
    model_reset();
    #12;
    check("in_reset");
    reset = 1'b0;
    steps(10, "idle");

    // ch0 continuous, period 3; also count ticks explicitly
    period[0*CW +: CW] = 8'd3;
    en[0] = 1'b1;
    nt = 0;
    for (int k = 0; k < 12; k++) begin
      step("ch0_p3");
      if (tick[0]) nt++;
    end
    n_cmp++;
    assert (nt == 4) else begin
      n_err++;
      $error("FAIL ch0_tick_count observed=%0d expected=4", nt);
    end
    en[0] = 1'b0;
    steps(3, "ch0_off");

    // ch1: abort after 3 edges, restart, period change mid-count ignored
    period[1*CW +: CW] = 8'd5;
    en[1] = 1'b1;
    steps(3, "ch1_run");
    en[1] = 1'b0;
    step("ch1_abort");
    en[1] = 1'b1;
    step("ch1_restart");
    period[1*CW +: CW] = 8'd9;
    steps(12, "ch1_pchg");
    en[1] = 1'b0;
    steps(2, "ch1_off");

    // ch2 one-shot
    period[2*CW +: CW] = 8'd4;
    oneshot[2] = 1'b1;
    en[2] = 1'b1;
    steps(20, "ch2_os");
    en[2] = 1'b0;
    step("ch2_drop");
    en[2] = 1'b1;
    steps(6, "ch2_os2");
    en[2] = 1'b0;
    oneshot[2] = 1'b0;
    steps(2, "ch2_off");

    // ch3 clamped periods 0 and 1
    period[3*CW +: CW] = 8'd0;
    en[3] = 1'b1;
    steps(8, "ch3_p0");
    en[3] = 1'b0;
    step("ch3_off");
    period[3*CW +: CW] = 8'd1;
    en[3] = 1'b1;
    steps(7, "ch3_p1");

    // sync clear during COUNT
    period[3*CW +: CW] = 8'd6;
    en[3] = 1'b0;
    step("ch3_idle");
    en[3] = 1'b1;
    steps(2, "ch3_p6");
    clr = 1'b1;
    step("clr");
    clr = 1'b0;
    steps(3, "after_clr");

    // async reset mid-cycle
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst");
    #1 reset = 1'b0;
    steps(6, "after_rst");
    en = '0;
    step("all_off");

    // tick counter saturation with period 2
    clr = 1'b1;
    step("clr2");
    clr = 1'b0;
    period[0*CW +: CW] = 8'd2;
    en[0] = 1'b1;
    steps(40, "sat");
    clr = 1'b1;
    step("clr3");
    clr = 1'b0;
    en = '0;
    step("idle2");

    // random
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NCH; i++) begin
        en[i] = ($urandom_range(7) != 0);
        oneshot[i] = ($urandom_range(3) == 0);
        period[i*CW +: CW] = CW'($urandom_range(7));
      end
      clr = ($urandom_range(80) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
